// File: rtl/sgb_cmd_pkg.sv
// rtl/sgb_cmd_pkg.sv - shared command constants and mailbox state encoding
package sgb_cmd_pkg;

  localparam logic [7:0] CMD_RESET_GAME   = 8'h80;
  localparam logic [7:0] CMD_RESET_MENU   = 8'h81;
  localparam logic [7:0] CMD_HOOK_OFF     = 8'h84;
  localparam logic [7:0] CMD_HOOK_OFF_10S = 8'h85;

  localparam logic [8:0] CMD_ADDR = 9'h000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RDADDR   = 3'd2,
    ST_VERIFY   = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_CLEAR    = 3'd5
  } mbox_state_t;

endpackage

// File: rtl/snescmd_port_arb.sv
// rtl/snescmd_port_arb.sv - snes_busy-gated BRAM write/read-back sequencing for the mailbox byte
module snescmd_port_arb
  import sgb_cmd_pkg::*;
#(
  parameter logic [8:0] ADDR = 9'h000
) (
  input  logic [2:0] state,
  input  logic [7:0] cmd,
  input  logic       snes_busy,
  input  logic [7:0] ram_rdata,
  output logic       ram_we,
  output logic [8:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       done,
  output logic       match
);

  mbox_state_t st;
  assign st = mbox_state_t'(state);

  // The port is only ever touched in a cycle where the SNES side is idle.
  always_comb begin
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    done      = 1'b0;
    case (st)
      ST_WRITE: begin
        ram_we    = ~snes_busy;
        ram_wdata = cmd;
        done      = ~snes_busy;
      end
      ST_RDADDR: done = ~snes_busy;
      ST_VERIFY: done = 1'b1;
      ST_CLEAR: begin
        ram_we = ~snes_busy;
        done   = ~snes_busy;
      end
      default: ;
    endcase
  end

  assign ram_addr = ADDR;
  assign match    = (ram_rdata == cmd);

endmodule

// File: rtl/snescmd_cmd_mailbox.sv
// rtl/snescmd_cmd_mailbox.sv - commits button commands into snescmd BRAM and hands them to the MCU
module snescmd_cmd_mailbox
  import sgb_cmd_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd86000000,
  parameter logic [3:0]  MAX_RETRY      = 4'd2,
  parameter logic [8:0]  CMD_ADDR       = sgb_cmd_pkg::CMD_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cheat_we,
  input  logic [8:0] cheat_addr,
  input  logic [7:0] cheat_data,
  output logic       cheat_rdy,
  input  logic       snes_busy,
  output logic       ram_we,
  output logic [8:0] ram_addr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic       mcu_cmd_valid,
  output logic [7:0] mcu_cmd,
  input  logic       mcu_ack,
  output logic       timeout_err,
  output logic       mismatch_err,
  input  logic       err_clr,
  output logic [7:0] drop_cnt
);

  mbox_state_t state, state_nxt;
  logic [7:0]  cmd_r;
  logic [3:0]  retry_r;
  logic [31:0] timer;

  logic accept, arb_done, arb_match;
  logic set_mismatch, set_timeout, do_retry, load_timer;

  assign cheat_rdy = (state == ST_IDLE);
  assign accept    = cheat_rdy & cheat_we & (cheat_addr == CMD_ADDR) & (cheat_data != 8'h00);

  snescmd_port_arb #(.ADDR(CMD_ADDR)) u_port_arb (
    .state     (state),
    .cmd       (cmd_r),
    .snes_busy (snes_busy),
    .ram_rdata (ram_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .done      (arb_done),
    .match     (arb_match)
  );

  always_comb begin
    state_nxt    = state;
    set_mismatch = 1'b0;
    set_timeout  = 1'b0;
    do_retry     = 1'b0;
    load_timer   = 1'b0;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_WRITE;
      ST_WRITE:  if (arb_done) state_nxt = ST_RDADDR;
      ST_RDADDR: if (arb_done) state_nxt = ST_VERIFY;
      ST_VERIFY: begin
        if (arb_match) begin
          state_nxt  = ST_WAIT_ACK;
          load_timer = 1'b1;
        end else if (retry_r < MAX_RETRY) begin
          state_nxt = ST_WRITE;
          do_retry  = 1'b1;
        end else begin
          // Give up without clearing: the byte is left for firmware to inspect.
          state_nxt    = ST_IDLE;
          set_mismatch = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (mcu_ack) begin
          state_nxt = ST_CLEAR;
        end else if (timer == 32'd0) begin
          state_nxt   = ST_CLEAR;
          set_timeout = 1'b1;
        end
      end
      ST_CLEAR:  if (arb_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cmd_r         <= 8'h00;
      retry_r       <= 4'd0;
      timer         <= 32'd0;
      mcu_cmd_valid <= 1'b0;
      mcu_cmd       <= 8'h00;
      timeout_err   <= 1'b0;
      mismatch_err  <= 1'b0;
      drop_cnt      <= 8'h00;
    end else begin
      state <= state_nxt;

      if (accept) begin
        cmd_r   <= cheat_data;
        retry_r <= 4'd0;
      end else if (do_retry) begin
        retry_r <= retry_r + 4'd1;
      end

      if (load_timer) begin
        timer <= TIMEOUT_CYCLES - 32'd1;
      end else if (state == ST_WAIT_ACK && timer != 32'd0) begin
        timer <= timer - 32'd1;
      end

      mcu_cmd_valid <= (state_nxt == ST_WAIT_ACK);
      mcu_cmd       <= (state_nxt == ST_WAIT_ACK) ? cmd_r : 8'h00;

      if (set_timeout) timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      if (set_mismatch) mismatch_err <= 1'b1;
      else if (err_clr) mismatch_err <= 1'b0;

      if (cheat_we && !accept && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: doc/snescmd_cmd_mailbox.md
Name: snescmd_cmd_mailbox

Overview:
- Responder side of the in-game button command path.
- Accepts single-byte command writes from the button/hook logic through the cheat_we/cheat_rdy handshake.
- Commits each accepted command into snescmd BRAM address 0x000, arbitrating against SNES accesses, then presents it to the MCU until the MCU acknowledges or a timeout expires.
- Clears the mailbox byte on completion. This owns the snescmd_rdy back-pressure the button logic depends on.

Parameters:
- TIMEOUT_CYCLES, 32'd86000000, cycles to wait in WAIT_ACK before forced clear (~1 s at 86 MHz).
- MAX_RETRY, 2, maximum re-writes after a read-back mismatch.
- CMD_ADDR, 9'h000, snescmd BRAM address of the mailbox byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cheat_we  in  1  command write strobe from button logic
- cheat_addr  in  9  command address; must equal CMD_ADDR, otherwise the write is ignored
- cheat_data  in  8  command byte (0x80, 0x81, 0x84, 0x85; 0x00 ignored)
- cheat_rdy  out  1  mailbox can accept a command this cycle
- snes_busy  in  1  SNES owns the snescmd BRAM port this cycle
- ram_we  out  1  BRAM write enable
- ram_addr  out  9  BRAM address
- ram_wdata  out  8  BRAM write data
- ram_rdata  in  8  BRAM read data, 1-cycle latency from ram_addr
- mcu_cmd_valid  out  1  command pending for MCU
- mcu_cmd  out  8  pending command byte
- mcu_ack  in  1  MCU consumed command (single-cycle pulse)
- timeout_err  out  1  sticky; set on forced clear
- mismatch_err  out  1  sticky; set when retries are exhausted
- err_clr  in  1  clears both sticky flags
- drop_cnt  out  8  saturating count of rejected cheat_we

Behaviour:
- Reset values: state IDLE; every output 0, except cheat_rdy=1 and ram_addr=CMD_ADDR. Internal cmd_r=0, retry_r=0, timer=0.
- States: IDLE, WRITE, RDADDR, VERIFY, WAIT_ACK, CLEAR.
- cheat_rdy = (state==IDLE). Combinational from the state register only.

IDLE:
- cheat_we & cheat_addr==CMD_ADDR & cheat_data!=0 latches cmd_r, sets retry_r=0, next WRITE.
- Any other cheat_we is dropped.
- A cheat_we arriving outside IDLE increments drop_cnt, saturating at 0xFF.

WRITE:
- While snes_busy=1, hold with ram_we=0.
- First cycle snes_busy=0: ram_we=1 for exactly one cycle, ram_addr=CMD_ADDR, ram_wdata=cmd_r; next RDADDR.

RDADDR:
- Drive ram_addr=CMD_ADDR, ram_we=0. Next VERIFY if snes_busy=0, else stay.

VERIFY:
- Sample ram_rdata.
- Equal to cmd_r: next WAIT_ACK, load timer=TIMEOUT_CYCLES-1.
- Not equal and retry_r<MAX_RETRY: retry_r+1, next WRITE.
- Not equal and retry_r==MAX_RETRY: set mismatch_err, next IDLE, leaving the byte untouched.

WAIT_ACK:
- mcu_cmd_valid=1 and mcu_cmd=cmd_r. These are registered, asserted on the cycle the state enters WAIT_ACK.
- mcu_ack: deassert mcu_cmd_valid next cycle, next CLEAR.
- Timer reaches 0 without ack: set timeout_err, next CLEAR.
- mcu_ack on the same cycle the timer expires: treated as ack; timeout_err is not set.

CLEAR:
- While snes_busy=1, wait.
- When free: ram_we=1, ram_wdata=0x00 for one cycle; next IDLE.

Error flags and counters:
- err_clr has lowest priority. A set event in the same cycle wins.
- drop_cnt is cleared only by reset.

Latency:
- Accepted command to mcu_cmd_valid is 4 cycles with no SNES contention (WRITE, RDADDR, VERIFY, then WAIT_ACK registered).
- Back-to-back accept rate is bounded by the MCU ack.

Reset:
- rst_n low mid-operation aborts immediately. The BRAM byte may retain a stale command; firmware clears it at boot.

Other rules:
- mcu_ack outside WAIT_ACK is ignored.
- ram_we is never asserted while snes_busy=1.

Decomposition:
- Shared package sgb_cmd_pkg holds:
  - command constants CMD_RESET_GAME=8'h80, CMD_RESET_MENU=8'h81, CMD_HOOK_OFF=8'h84, CMD_HOOK_OFF_10S=8'h85;
  - CMD_ADDR;
  - the state enum.
- One natural sub-module: snescmd_port_arb. It wraps the snes_busy-gated write/read-back sequencing (WRITE/RDADDR/VERIFY/CLEAR access) and returns done/match to the main FSM.

Test Plan:
- Command 0x80 with snes_busy=0, then mcu_ack 10 cycles later:
  - BRAM[0]=0x80 written once;
  - mcu_cmd_valid rises 4 cycles after cheat_we, with mcu_cmd=0x80;
  - after ack, one write of 0x00 to address 0;
  - cheat_rdy returns to 1.
- snes_busy held high 5 cycles at cheat_we of 0x85:
  - ram_we stays 0 for those cycles, then pulses once with data 0x85;
  - mcu_cmd_valid rises 9 cycles after cheat_we.
- Read-back forced to 0x00 for three VERIFYs (MAX_RETRY=2):
  - three writes of the command observed;
  - mismatch_err=1; state IDLE; mcu_cmd_valid never asserted.
- TIMEOUT_CYCLES=16, no ack:
  - mcu_cmd_valid is high 16 cycles;
  - timeout_err=1, BRAM[0] cleared to 0x00.
  - Repeat with ack on the 16th cycle: timeout_err stays 0.
- 300 cheat_we pulses issued during WAIT_ACK: drop_cnt=0xFF, pending mcu_cmd unchanged.
- rst_n asserted during WRITE contention:
  - all outputs at reset values the same cycle (asynchronous);
  - the next command after release is accepted normally.
